// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg: shared definitions for the AES-128 inverse cipher.
//   state_t          - FSM state encoding
//   RCON             - round constant table, indexed 1..10 (other slots zero)
//   xtime / gf_mul   - GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
//   gf_inv           - multiplicative inverse (a^254, with 0 -> 0)
//   sbox / sub_word  - forward S-box, used by the key schedule
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_EXPAND,
        ST_INIT_ARK,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] r;
        p = a;
        q = b;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (q[0]) r = r ^ p;
            p = xtime(p);
            q = q >> 1;
        end
        return r;
    endfunction

    // Square-and-multiply over the exponent 254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] e;
        p = a;
        r = 8'h01;
        e = 8'hfe;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[0]) r = gf_mul(r, p);
            p = gf_mul(p, p);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// -----------------------------------------------------------------------------
// aes_inv_sbox: combinational AES inverse S-box (inverse affine, then GF inverse).
//   a - input byte
//   y - InvSubBytes(a)
// -----------------------------------------------------------------------------
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] b;

    // Inverse affine: rotate-left by 1, 3 and 6, then xor 0x05.
    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(b);

endmodule

// File: rtl/aes_inv_cipher.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher: iterative AES-128 decryptor, one round per clock.
//   i_clock   - clock, rising edge
//   i_reset   - asynchronous active-high reset
//   i_start   - decrypt request, accepted in IDLE or DONE only
//   i_cipher  - ciphertext block, byte n at bits [8n:8n+7]
//   i_key     - AES-128 key, same byte ordering
//   o_plain   - plaintext, valid while o_is_done is high, zero otherwise
//   o_busy    - operation in progress
//   o_is_done - level, high in DONE
// Build option: define AES_DEC_KEY_CACHE_EN to remember the last key and its
// round key 10, so a repeated key skips the forward expansion.
// -----------------------------------------------------------------------------
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [0:127] i_cipher,
    input  logic [0:127] i_key,
    output logic [0:127] o_plain,
    output logic         o_busy,
    output logic         o_is_done
);

    localparam logic [3:0] LAST_KEY    = 4'(NUM_ROUNDS);
    localparam logic [3:0] FIRST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t       state;
    state_t       state_next;
    logic [0:127] data;
    logic [0:127] key;
    logic [3:0]   rnd;
    logic [3:0]   kcnt;
    logic         accept;
    logic         cache_hit;
    logic [0:127] key_load;

    assign accept = i_start && (state == ST_IDLE || state == ST_DONE);

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_valid;
    logic [0:127] cache_key;
    logic [0:127] cache_rk10;

    assign cache_hit = cache_valid && (i_key == cache_key);
    assign key_load  = cache_hit ? cache_rk10 : i_key;
`else
    assign cache_hit = 1'b0;
    assign key_load  = i_key;
`endif

    // ---------------- key schedule (forward and backward step) ----------------
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [31:0]  bw0, bw1, bw2, bw3;
    logic [31:0]  rot_src;
    logic [31:0]  sub_w;
    logic [3:0]   rc_idx;
    logic [0:127] key_fwd;
    logic [0:127] key_back;

    assign kw0 = key[0  +: 32];
    assign kw1 = key[32 +: 32];
    assign kw2 = key[64 +: 32];
    assign kw3 = key[96 +: 32];

    // Key register holds rk(r+1) in ROUND and rk1 in FINAL, so the step back
    // uses Rcon[r+1] (10..2) and Rcon[1]; KEY_EXPAND uses Rcon[kcnt].
    always_comb begin
        rc_idx = rnd + 4'd1;
        case (state)
            ST_KEY_EXPAND: rc_idx = kcnt;
            ST_FINAL:      rc_idx = 4'd1;
            default:       rc_idx = rnd + 4'd1;
        endcase
    end

    assign bw3 = kw3 ^ kw2;
    assign bw2 = kw2 ^ kw1;
    assign bw1 = kw1 ^ kw0;

    // One SubWord serves both directions: forward takes w3, backward the
    // recovered previous w3.
    assign rot_src = (state == ST_KEY_EXPAND) ? kw3 : bw3;
    assign sub_w   = sub_word({rot_src[23:0], rot_src[31:24]}) ^ {RCON[rc_idx], 24'h0};

    assign fw0 = kw0 ^ sub_w;
    assign fw1 = kw1 ^ fw0;
    assign fw2 = kw2 ^ fw1;
    assign fw3 = kw3 ^ fw2;
    assign bw0 = kw0 ^ sub_w;

    assign key_fwd  = {fw0, fw1, fw2, fw3};
    assign key_back = {bw0, bw1, bw2, bw3};

    // ---------------- round datapath ----------------
    logic [0:127] isr;
    logic [0:127] isb;
    logic [0:127] ark;
    logic [0:127] imc;

    for (genvar c = 0; c < 4; c++) begin : g_isr_col
        for (genvar r = 0; r < 4; r++) begin : g_isr_row
            assign isr[8*(4*c+r) +: 8] = data[8*(4*((c+4-r)%4)+r) +: 8];
        end
    end

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .a (isr[8*n +: 8]),
            .y (isb[8*n +: 8])
        );
    end

    assign ark = isb ^ key_back;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[8*(4*c)   +: 8];
        assign a1 = ark[8*(4*c+1) +: 8];
        assign a2 = ark[8*(4*c+2) +: 8];
        assign a3 = ark[8*(4*c+3) +: 8];
        assign imc[8*(4*c)   +: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^
                                     gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
        assign imc[8*(4*c+1) +: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^
                                     gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
        assign imc[8*(4*c+2) +: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^
                                     gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
        assign imc[8*(4*c+3) +: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^
                                     gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        o_is_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_next = cache_hit ? ST_INIT_ARK : ST_KEY_EXPAND;
            end
            ST_KEY_EXPAND: begin
                o_busy = 1'b1;
                if (kcnt == LAST_KEY) state_next = ST_INIT_ARK;
            end
            ST_INIT_ARK: begin
                o_busy     = 1'b1;
                state_next = ST_ROUND;
            end
            ST_ROUND: begin
                o_busy = 1'b1;
                if (rnd == 4'd1) state_next = ST_FINAL;
            end
            ST_FINAL: begin
                o_busy     = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                o_is_done = 1'b1;
                if (i_start) state_next = cache_hit ? ST_INIT_ARK : ST_KEY_EXPAND;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            data    <= '0;
            key     <= '0;
            rnd     <= '0;
            kcnt    <= '0;
            o_plain <= '0;
        end else if (accept) begin
            data    <= i_cipher;
            key     <= key_load;
            rnd     <= '0;
            kcnt    <= 4'd1;
            o_plain <= '0;
        end else begin
            case (state)
                ST_KEY_EXPAND: begin
                    key <= key_fwd;
                    if (kcnt != LAST_KEY) kcnt <= kcnt + 4'd1;
                end
                ST_INIT_ARK: begin
                    data <= data ^ key;
                    rnd  <= FIRST_ROUND;
                end
                ST_ROUND: begin
                    data <= imc;
                    key  <= key_back;
                    if (rnd != 4'd1) rnd <= rnd - 4'd1;
                end
                ST_FINAL: begin
                    o_plain <= ark;
                    key     <= key_back;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk10  <= '0;
        end else if (accept && !cache_hit) begin
            cache_valid <= 1'b0;
            cache_key   <= i_key;
        end else if (state == ST_KEY_EXPAND && kcnt == LAST_KEY) begin
            cache_valid <= 1'b1;
            cache_rk10  <= key_fwd;
        end
    end
`endif

endmodule

// File: tb/tb_aes_inv_cipher.sv
module tb_aes_inv_cipher;

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_start = 1'b0;
    logic [0:127] i_cipher = '0;
    logic [0:127] i_key = '0;
    logic [0:127] o_plain;
    logic         o_busy;
    logic         o_is_done;

    int checks = 0;
    int failures = 0;

    bit           cache_en = 1'b0;
    bit           cache_valid = 1'b0;
    logic [0:127] cache_key = '0;

    logic [7:0]   sbox_tab [256];

    localparam logic [0:127] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C_PT    = 128'h00112233445566778899aabbccddeeff;

    aes_inv_cipher #(.NUM_ROUNDS(10)) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_cipher  (i_cipher),
        .i_key     (i_key),
        .o_plain   (o_plain),
        .o_busy    (o_busy),
        .o_is_done (o_is_done)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- independent encryption model ----------------
    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = '0;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = tb_xtime(p);
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (tb_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_tab[a] = s;
        end
    endtask

    function automatic logic [0:127] tb_encrypt(input logic [0:127] pt, input logic [0:127] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                       sbox_tab[tmp[31:24]]} ^ {rc, 24'h0};
                rc = tb_xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sbox_tab[s[n]];
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) s[4*c+k] = t[4*((c+k)%4)+k];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = tb_xtime(a0) ^ tb_xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ tb_xtime(a1) ^ tb_xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ tb_xtime(a2) ^ tb_xtime(a3) ^ a3;
                    s[4*c+3] = tb_xtime(a0) ^ a0 ^ a1 ^ a2 ^ tb_xtime(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        cache_valid = 1'b0;
    endtask

    // Inputs are scrambled right after acceptance; poke_at > 0 pulses i_start
    // that many cycles into the operation.
    task automatic decrypt(input string tag, input logic [0:127] ct, input logic [0:127] key,
                           input logic [0:127] exp_pt, input int poke_at);
        int cyc;
        int exp_lat;
        exp_lat = (cache_en && cache_valid && key == cache_key) ? 11 : 21;
        i_cipher = ct;
        i_key    = key;
        i_start  = 1'b1;
        @(posedge i_clock);
        #1;
        i_start  = 1'b0;
        i_cipher = ~ct;
        i_key    = ~key;
        check({tag, "_busy"}, 128'(o_busy), 128'(1));
        check({tag, "_plain_busy"}, o_plain, '0);
        cyc = 0;
        while (!o_is_done && cyc < 60) begin
            i_start = (poke_at != 0 && cyc == poke_at);
            @(posedge i_clock);
            #1;
            cyc++;
        end
        i_start = 1'b0;
        check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
        check({tag, "_plain"}, o_plain, exp_pt);
        check({tag, "_busy_done"}, 128'(o_busy), 128'(0));
        if (o_is_done) begin
            cache_valid = 1'b1;
            cache_key   = key;
        end
    endtask

    initial begin
        logic [0:127] rk;
        logic [0:127] rp;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_en = 1'b1;
`endif
        build_sbox();
        do_reset();
        check("rst_plain", o_plain, '0);
        check("rst_busy", 128'(o_busy), 128'(0));
        check("rst_done", 128'(o_is_done), 128'(0));

        decrypt("appB", B_CT, B_KEY, B_PT, 0);
        repeat (3) @(posedge i_clock);
        #1;
        check("hold_done", 128'(o_is_done), 128'(1));
        check("hold_plain", o_plain, B_PT);

        decrypt("appB_again", B_CT, B_KEY, B_PT, 0);
        decrypt("appC", C_CT, C_KEY, C_PT, 0);
        decrypt("busy_start", B_CT, B_KEY, B_PT, 5);

        // Reset in the middle of an operation.
        i_cipher = B_CT;
        i_key    = B_KEY;
        i_start  = 1'b1;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        repeat (11) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        #1;
        check("midrst_plain", o_plain, '0);
        check("midrst_busy", 128'(o_busy), 128'(0));
        check("midrst_done", 128'(o_is_done), 128'(0));
        @(posedge i_clock);
        #1;
        check("midrst_busy_next", 128'(o_busy), 128'(0));
        i_reset = 1'b0;
        cache_valid = 1'b0;
        decrypt("after_rst", B_CT, B_KEY, B_PT, 0);

        for (int v = 0; v < 1000; v++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            decrypt($sformatf("loop%0d", v), tb_encrypt(rp, rk), rk, rp, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
